mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 16: address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 16: data width in bits.
REQ-003 SHALL have parameter MEM_LATENCY, default 4: cycles from a main-memory read issue to its mem_data_valid.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_miss  in  1  I-cache miss pending; level signal.
- i_miss_addr  in  AWIDTH  I-cache miss address.
- d_miss  in  1  D-cache miss pending; level signal.
- d_miss_addr  in  AWIDTH  D-cache miss address.
- d_wr_req  in  1  store write-through request.
- d_wr_addr  in  AWIDTH  store address.
- d_wr_data  in  DWIDTH  store data.
- mem_data_valid  in  1  main-memory read data valid.
- mem_en  out  1  main-memory enable.
- mem_wr  out  1  main-memory write strobe.
- mem_addr  out  AWIDTH  main-memory address.
- mem_data_in  out  DWIDTH  main-memory write data.
- d_wr_ack  out  1  one-cycle pulse; store accepted.
- i_fill_data_wen, d_fill_data_wen  out  1 each  cache data-array write enables.
- i_fill_tag_wen, d_fill_tag_wen  out  1 each  cache tag-array write enables.
- fill_addr  out  AWIDTH  address of the word currently being filled.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement states IDLE, WRITE, FILL and DONE; the state SHALL be registered.
REQ-006 In IDLE, the arbiter SHALL select d_wr_req first, then d_miss, then i_miss; REQ-020 amends the miss order.
- A selected store SHALL move the FSM to WRITE.
- A selected miss SHALL latch the requester ID and base = miss_addr & ~16'h000F, then move the FSM to FILL.
REQ-007 WRITE SHALL last exactly 1 cycle and drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data and d_wr_ack=1; it SHALL then return to IDLE.
REQ-008 FILL SHALL issue 8 reads, one per cycle, using a 3-bit issue counter k = 0..7.
- Each read SHALL drive mem_en=1, mem_wr=0 and mem_addr = base + 2*k.
- After k=7, mem_en SHALL be 0 for the rest of the fill.
REQ-009 A 3-bit return counter r SHALL increment on each mem_data_valid received in FILL.
- On each such valid, the arbiter SHALL assert the fill_data_wen of the owning requester and drive fill_addr = base + 2*r.
REQ-010 When r=7 and mem_data_valid=1, the arbiter SHALL also assert the owner's fill_tag_wen in that same cycle and then move to DONE.
REQ-011 DONE SHALL last exactly 1 cycle with no memory access, so the served miss line can deassert; the FSM SHALL then return to IDLE.
REQ-012 Latency: with a miss first seen in IDLE at cycle 0, reads SHALL issue in cycles 1..8, the tag write SHALL occur in cycle 8+MEM_LATENCY, and a new grant SHALL be possible at cycle 10+MEM_LATENCY.
REQ-013 No request SHALL be granted while busy=1; requests arriving then SHALL wait, being level-held.
REQ-014 mem_data_valid outside FILL SHALL be ignored.
REQ-015 Base address arithmetic SHALL wrap modulo 2^AWIDTH.
REQ-016 When idle, all enables SHALL be 0; mem_addr and fill_addr SHALL be 0.

Reset
REQ-017 rst=1 SHALL immediately force state=IDLE, clear both counters and the owner register, and drive every output to 0, independent of clk.
REQ-018 A reset during FILL SHALL abandon the fill; no tag write SHALL occur, and stale memory returns after reset SHALL be ignored per REQ-014.

Configuration
REQ-019 Macro ARB_ROUND_ROBIN_EN SHALL control miss arbitration fairness.
REQ-020 With ARB_ROUND_ROBIN_EN defined: when d_miss and i_miss are both high in IDLE, the requester not served by the previous fill SHALL win, and the last-served register SHALL reset to I. Without it: d_miss SHALL always beat i_miss. In both cases d_wr_req keeps top priority.

Verification
REQ-021 Scenario: d_miss=1, d_miss_addr=16'h1236, MEM_LATENCY=4 -> mem_addr 16'h1230..16'h123E in cycles 1..8; d_fill_data_wen in cycles 5..12 with fill_addr 16'h1230..16'h123E; d_fill_tag_wen in cycle 12; DONE in cycle 13.
REQ-022 Scenario: d_wr_req=1, addr 16'h0040, data 16'hBEEF, with d_miss=1 in the same cycle -> a 1-cycle write with mem_wr=1 and d_wr_ack=1, followed by the fill of base 16'h0040.
REQ-023 Scenario: i_miss and d_miss both held high -> without the macro, D is served then I; with the macro and the previous fill served to D, I wins.
REQ-024 Scenario: i_miss_addr=16'hFFF8 -> reads 16'hFFF0..16'hFFFE, with no wrap into 16'h0000.
REQ-025 Scenario: rst pulsed at cycle 6 of a fill -> outputs 0 at once, no tag_wen, mem_data_valid pulses over the next 4 cycles ignored, busy=0.
REQ-026 Scenario: i_miss raised while busy in FILL(D) -> no I grant until the cycle after DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache line fills and D-cache write-through stores onto one memory port.
// Fill: 8 reads in cycles 1..8 after grant, tag write at 8+MEM_LATENCY; stores take 1 cycle.
// Requests are level-held and simply wait while busy. Macro ARB_ROUND_ROBIN_EN enables fair miss arbitration.
module mem_arbiter #(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [AWIDTH-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [AWIDTH-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [AWIDTH-1:0] d_wr_addr,
  input  logic [DWIDTH-1:0] d_wr_data,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  output logic              d_wr_ack,
  output logic              i_fill_data_wen,
  output logic              d_fill_data_wen,
  output logic              i_fill_tag_wen,
  output logic              d_fill_tag_wen,
  output logic [AWIDTH-1:0] fill_addr,
  output logic              busy
);

  localparam logic [AWIDTH-1:0] LINE_MASK = ~AWIDTH'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              owner_d;
  logic [AWIDTH-1:0] base;
  logic [2:0]        issue_cnt;
  logic [2:0]        ret_cnt;
  logic              issue_done;
  logic              pick_d;
  logic              miss_grant;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who got the previous fill so a contended miss goes to the other side.
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (miss_grant) begin
      last_d <= pick_d;
    end
  end

  always_comb begin
    pick_d = d_miss & (~i_miss | ~last_d);
  end
`else
  always_comb begin
    pick_d = d_miss;
  end
`endif

  always_comb begin
    miss_grant = (state == IDLE) & ~d_wr_req & (d_miss | i_miss);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      base       <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (miss_grant) begin
        owner_d    <= pick_d;
        base       <= (pick_d ? d_miss_addr : i_miss_addr) & LINE_MASK;
        issue_cnt  <= '0;
        ret_cnt    <= '0;
        issue_done <= 1'b0;
      end else if (state == FILL) begin
        if (!issue_done) begin
          issue_cnt <= issue_cnt + 3'd1;
          if (issue_cnt == 3'd7) begin
            issue_done <= 1'b1;
          end
        end
        if (mem_data_valid) begin
          ret_cnt <= ret_cnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    mem_en          = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = '0;
    mem_data_in     = '0;
    d_wr_ack        = 1'b0;
    i_fill_data_wen = 1'b0;
    d_fill_data_wen = 1'b0;
    i_fill_tag_wen  = 1'b0;
    d_fill_tag_wen  = 1'b0;
    fill_addr       = '0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (d_wr_req) begin
          state_nxt = WRITE;
        end else if (d_miss || i_miss) begin
          state_nxt = FILL;
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_nxt   = IDLE;
      end
      FILL: begin
        if (!issue_done) begin
          mem_en   = 1'b1;
          mem_addr = base + AWIDTH'({issue_cnt, 1'b0});
        end
        // Returns are counted independently of issue; they overlap once latency < 8.
        if (mem_data_valid) begin
          d_fill_data_wen = owner_d;
          i_fill_data_wen = ~owner_d;
          fill_addr       = base + AWIDTH'({ret_cnt, 1'b0});
          if (ret_cnt == 3'd7) begin
            d_fill_tag_wen = owner_d;
            i_fill_tag_wen = ~owner_d;
            state_nxt      = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_data_valid;
  logic        mem_en, mem_wr, d_wr_ack, busy;
  logic [15:0] mem_addr, mem_data_in, fill_addr;
  logic        i_fill_data_wen, d_fill_data_wen, i_fill_tag_wen, d_fill_tag_wen;

  logic [LAT-1:0] rd_pipe = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns read data exactly LAT cycles after each issued read; it ignores reset.
  always @(posedge clk) rd_pipe <= {rd_pipe[LAT-2:0], mem_en & ~mem_wr};
  assign mem_data_valid = rd_pipe[LAT-1];

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .d_wr_ack(d_wr_ack),
    .i_fill_data_wen(i_fill_data_wen), .d_fill_data_wen(d_fill_data_wen),
    .i_fill_tag_wen(i_fill_tag_wen), .d_fill_tag_wen(d_fill_tag_wen),
    .fill_addr(fill_addr), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, mem_en, 0);
    check({tag, "_wr"}, mem_wr, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_data_in, 0);
    check({tag, "_ack"}, d_wr_ack, 0);
    check({tag, "_wen"}, {i_fill_data_wen, d_fill_data_wen, i_fill_tag_wen, d_fill_tag_wen}, 0);
    check({tag, "_faddr"}, fill_addr, 0);
  endtask

  // Called in cycle 1 of a fill (first cycle after the grant); ends in cycle 10+LAT.
  task automatic fill_check(input logic is_d, input logic [15:0] base, input logic keep);
    logic rd, ret;
    logic [15:0] exp_ma, exp_fa;
    for (int c = 1; c <= 9 + LAT; c++) begin
      rd     = (c <= 8);
      ret    = (c >= 1 + LAT) && (c <= 8 + LAT);
      exp_ma = rd ? base + 16'(2 * (c - 1)) : 16'h0;
      exp_fa = ret ? base + 16'(2 * (c - 1 - LAT)) : 16'h0;
      check($sformatf("busy_%h_c%0d", base, c), busy, 1);
      check($sformatf("en_%h_c%0d", base, c), mem_en, rd);
      check($sformatf("wr_%h_c%0d", base, c), mem_wr, 0);
      check($sformatf("maddr_%h_c%0d", base, c), mem_addr, exp_ma);
      check($sformatf("dwen_%h_c%0d", base, c), d_fill_data_wen, ret && is_d);
      check($sformatf("iwen_%h_c%0d", base, c), i_fill_data_wen, ret && !is_d);
      check($sformatf("faddr_%h_c%0d", base, c), fill_addr, exp_fa);
      check($sformatf("dtag_%h_c%0d", base, c), d_fill_tag_wen, (c == 8 + LAT) && is_d);
      check($sformatf("itag_%h_c%0d", base, c), i_fill_tag_wen, (c == 8 + LAT) && !is_d);
      if (c == 9 + LAT && !keep) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
      tick();
    end
    check($sformatf("idle_after_%h", base), busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    {i_miss, d_miss, d_wr_req} = '0;
    {i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data} = '0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    check_quiet("idle");

    // D miss at 0x1236 fills line 0x1230.
    d_miss = 1'b1; d_miss_addr = 16'h1236;
    #1 check("a_grant_busy", busy, 0);
    tick();
    fill_check(1'b1, 16'h1230, 1'b0);

    // Store beats a simultaneous D miss, then the miss is served.
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h0045;
    #1 check("b_grant_busy", busy, 0);
    tick();
    check("b_wr_busy", busy, 1);
    check("b_wr_en", mem_en, 1);
    check("b_wr_wr", mem_wr, 1);
    check("b_wr_addr", mem_addr, 16'h0040);
    check("b_wr_data", mem_data_in, 16'hBEEF);
    check("b_wr_ack", d_wr_ack, 1);
    d_wr_req = 1'b0;
    tick();
    check("b_idle_busy", busy, 0);
    check("b_idle_ack", d_wr_ack, 0);
    tick();
    fill_check(1'b1, 16'h0040, 1'b0);

    // Top-of-memory line must not wrap.
    i_miss = 1'b1; i_miss_addr = 16'hFFF8;
    tick();
    fill_check(1'b0, 16'hFFF0, 1'b0);

    // Both misses high after an I fill: D first, I waits until after DONE.
    d_miss = 1'b1; d_miss_addr = 16'h3004;
    i_miss = 1'b1; i_miss_addr = 16'h200A;
    tick();
    fill_check(1'b1, 16'h3000, 1'b0);
    tick();
    fill_check(1'b0, 16'h2000, 1'b0);

    // Both high again with D re-requesting immediately after its fill.
    d_miss = 1'b1; d_miss_addr = 16'h4000;
    i_miss = 1'b1; i_miss_addr = 16'h6000;
    tick();
    fill_check(1'b1, 16'h4000, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    tick();
    fill_check(1'b0, 16'h6000, 1'b0);
    tick();
    fill_check(1'b1, 16'h4000, 1'b0);
`else
    tick();
    fill_check(1'b1, 16'h4000, 1'b0);
    tick();
    fill_check(1'b0, 16'h6000, 1'b0);
`endif

    // Reset in cycle 6 of a fill abandons it; stale returns are ignored.
    i_miss = 1'b1; i_miss_addr = 16'h5000;
    tick();
    for (int c = 1; c < 6; c++) tick();
    check("f_c6_en", mem_en, 1);
    check("f_c6_addr", mem_addr, 16'h500A);
    #1 rst = 1'b1;
    #1 check_quiet("f_rst_async");
    i_miss = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("f_post_busy_%0d", c), busy, 0);
      check($sformatf("f_post_en_%0d", c), mem_en, 0);
      check($sformatf("f_post_wen_%0d", c),
            {i_fill_data_wen, d_fill_data_wen, i_fill_tag_wen, d_fill_tag_wen}, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
